// File: rtl/seg_scan_ctrl_if.sv
// Frame handshake between the digit converters and the display scanner.
// The source drives the packed 7-segment codes and valid. The scanner returns ready.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic [7*NUM_DIGITS-1:0] frame_in;
  logic                    frame_valid;
  logic                    frame_ready;

  modport master (output frame_in, output frame_valid, input frame_ready);
  modport slave  (input frame_in, input frame_valid, output frame_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scanner: a double-buffered frame is shown one digit per DIV-cycle slot.
// Define LEADING_ZERO_BLANK_EN to darken the leading zero digits of each frame.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 1000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                  clock,
  input  logic                  rst,
  seg_scan_ctrl_if.slave        frame_bus,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  frame_done
);

  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
  localparam logic [TICK_W-1:0] BLANK_END = TICK_W'(BLANK_CYC);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_e;
  typedef logic [NUM_DIGITS-1:0][6:0] frame_t;

  state_e                  state_q, state_d;
  logic [TICK_W-1:0]       tick_q, tick_d;
  logic [DIG_W-1:0]        digit_q, digit_d;
  frame_t                  pending_q, pending_d;
  frame_t                  active_q, active_d;
  logic                    pending_vld_q, pending_vld_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    frame_done_q, frame_done_d;
  logic                    accept, wrap, promote, digit_hidden;

  assign frame_bus.frame_ready = !pending_vld_q;
  assign accept = frame_bus.frame_valid && !pending_vld_q;
  assign wrap   = (state_q != IDLE) && (tick_q == TICK_LAST) && (digit_q == DIG_LAST);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] SEG_ZERO = 7'b0111111;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;

  // Zero digits are masked from the top down until the first nonzero one; digit 0 always shows.
  function automatic logic [NUM_DIGITS-1:0] lzb_mask(input frame_t f);
    logic run;
    lzb_mask = '0;
    run      = 1'b1;
    for (int d = NUM_DIGITS - 1; d > 0; d--) begin
      run         = run && (f[d] == SEG_ZERO);
      lzb_mask[d] = run;
    end
  endfunction

  assign mask_d       = promote ? lzb_mask(pending_q) : mask_q;
  assign digit_hidden = mask_q[digit_q];

  always_ff @(posedge clock) begin
    mask_q <= mask_d;
  end
`else
  assign digit_hidden = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave a latch behind.
    state_d       = state_q;
    tick_d        = tick_q;
    digit_d       = digit_q;
    pending_d     = pending_q;
    pending_vld_d = pending_vld_q;
    active_d      = active_q;
    promote       = 1'b0;
    seg_d         = 7'd0;
    digit_en_d    = '0;
    frame_done_d  = wrap;

    if (accept) begin
      pending_d     = frame_t'(frame_bus.frame_in);
      pending_vld_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pending_vld_q) begin
          promote = 1'b1;
          tick_d  = '0;
          digit_d = '0;
          state_d = (BLANK_CYC > 0) ? BLANK : SHOW;
        end
      end
      default: begin
        tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
        if (tick_q == TICK_LAST)
          digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DIG_W'(1);
        // The check looks at pending_vld_q from the start of the cycle. A frame accepted on the wrap waits one more scan.
        promote = wrap && pending_vld_q;
        state_d = ((BLANK_CYC > 0) && (tick_d < BLANK_END)) ? BLANK : SHOW;
      end
    endcase

    // Accept needs pending empty and promote needs it full, so they never collide.
    if (promote) begin
      active_d      = pending_q;
      pending_vld_d = 1'b0;
    end

    if ((state_q == SHOW) && !digit_hidden) begin
      seg_d               = active_q[digit_q];
      digit_en_d[digit_q] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q       <= IDLE;
      tick_q        <= '0;
      digit_q       <= '0;
      pending_vld_q <= 1'b0;
      seg_q         <= 7'd0;
      digit_en_q    <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      digit_q       <= digit_d;
      pending_vld_q <= pending_vld_d;
      seg_q         <= seg_d;
      digit_en_q    <= digit_en_d;
      frame_done_q  <= frame_done_d;
    end
  end

  // NOTE: frame storage is not reset. Valid flags and the FSM gate every read of it.
  always_ff @(posedge clock) begin
    pending_q <= pending_d;
    active_q  <= active_d;
  end

  assign seg        = seg_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;

endmodule
